// File: rtl/enum_type_pkg.sv
// Shared button-channel state encoding, default timing constants and a sizing helper.
package enum_type;

    typedef enum logic [1:0] {
        B_IDLE,
        B_HOLD,
        B_DELAY,
        B_REPEAT
    } btn_state_t;

    localparam int DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int DAS_CYC_DEF      = 8_500_000;
    localparam int ARR_CYC_DEF      = 2_500_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer then stable-for-N debounce; stable follows the pin DEBOUNCE_CYC+2 edges later.
// rise is a one-cycle registered pulse on an accepted 0->1 change; no backpressure.
module btn_debounce
    import enum_type::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic stable,
    output logic rise
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Any return to the accepted level restarts the count, so bounces never flip stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                rise   <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_repeater.sv
// Four debounced buttons to one-cycle press pulses with DAS/ARR hold-to-repeat; press one edge after held rises.
// Registered outputs, fire-and-forget pulses, no backpressure.
module input_repeater
    import enum_type::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int DAS_CYC      = DAS_CYC_DEF,
    parameter int ARR_CYC      = ARR_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] usr_btn,
    input  logic [3:0] repeat_mask,
    output logic [3:0] press,
    output logic [3:0] held
);

    localparam int               REP_W    = $clog2(max_int(DAS_CYC, ARR_CYC)) + 1;
    localparam logic [REP_W-1:0] DAS_LAST = REP_W'(DAS_CYC - 1);
    localparam logic [REP_W-1:0] ARR_LAST = REP_W'(ARR_CYC - 1);

    logic [3:0] stable;
    logic [3:0] rise;

    assign held = stable;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn

        btn_state_t       state;
        btn_state_t       state_nxt;
        logic [REP_W-1:0] rep_cnt;
        logic [REP_W-1:0] rep_cnt_nxt;
        logic             press_q;
        logic             press_nxt;

        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .btn    (usr_btn[gi]),
            .stable (stable[gi]),
            .rise   (rise[gi])
        );

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state   <= B_IDLE;
                rep_cnt <= '0;
                press_q <= 1'b0;
            end else begin
                state   <= state_nxt;
                rep_cnt <= rep_cnt_nxt;
                press_q <= press_nxt;
            end
        end

        // Release outranks a mask clear, which outranks a due repeat.
        always_comb begin
            state_nxt   = state;
            rep_cnt_nxt = rep_cnt;
            press_nxt   = 1'b0;
            case (state)
                B_IDLE: begin
                    if (rise[gi]) begin
                        press_nxt   = 1'b1;
                        rep_cnt_nxt = '0;
                        state_nxt   = repeat_mask[gi] ? B_DELAY : B_HOLD;
                    end
                end
                B_HOLD: begin
                    if (!stable[gi]) begin
                        state_nxt = B_IDLE;
                    end
                end
                B_DELAY, B_REPEAT: begin
                    if (!stable[gi]) begin
                        state_nxt = B_IDLE;
                    end else if (!repeat_mask[gi]) begin
                        state_nxt = B_HOLD;
                    end else if (rep_cnt == ((state == B_DELAY) ? DAS_LAST : ARR_LAST)) begin
                        press_nxt   = 1'b1;
                        rep_cnt_nxt = '0;
                        state_nxt   = B_REPEAT;
                    end else begin
                        rep_cnt_nxt = rep_cnt + REP_W'(1);
                    end
                end
                default: begin
                    state_nxt = B_IDLE;
                end
            endcase
        end

        assign press[gi] = press_q;

    end

endmodule

// File: doc/input_repeater.md
# input_repeater

Conditions the four raw push-buttons into clean one-cycle action pulses, with per-button hold-to-repeat using delayed auto-shift (DAS) and auto-repeat rate (ARR) timing. It sits between the board `usr_btn` pins and the game control stage. `control` consumes `press` in place of raw button levels, so held left/right/down moves repeat the way players expect. All four channels are identical and fully independent.

## Interface

- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥1.
- `DAS_CYC`, 8_500_000: cycles from the initial press pulse to the first repeat pulse (170 ms); must be ≥1.
- `ARR_CYC`, 2_500_000: cycles between subsequent repeat pulses (50 ms); must be ≥1.
- `clk`  in  1  the 50 MHz design clock (`clk_50MHz` at top level).
- `reset_n`  in  1  asynchronous, active-low reset.
- `usr_btn`  in  4  raw, asynchronous button levels; active high.
- `repeat_mask`  in  4  per-button repeat enable; sampled every cycle.
- `press`  out  4  one-cycle pulse on each accepted press and on each repeat.
- `held`  out  4  registered debounced level.

## Operation

- **Synchronizer.** Per bit, a 2-flop chain `s1` → `s2`.
- **Debounce.** Per bit, a counter `cnt` of width `$clog2(DEBOUNCE_CYC)+1`.
  - If `s2 == stable`, clear `cnt`.
  - Otherwise, if `cnt == DEBOUNCE_CYC-1`, load `stable <= s2` and clear `cnt`.
  - Otherwise, increment `cnt`.
  - `held = stable`.
- **Per-bit FSM.** States: `B_IDLE`, `B_HOLD`, `B_DELAY`, `B_REPEAT`. `rep_cnt` width is sized for `max(DAS_CYC, ARR_CYC)`.
  - **`B_IDLE`:** on the `stable` rising edge, pulse `press` and clear `rep_cnt`. Go to `B_DELAY` if `repeat_mask` is 1, else `B_HOLD`.
  - **`B_HOLD`:** no pulses. Go to `B_IDLE` when `stable` is 0.
  - **`B_DELAY`:**
    - `stable` 0: go to `B_IDLE`.
    - `repeat_mask` 0: go to `B_HOLD`.
    - `rep_cnt == DAS_CYC-1`: pulse `press`, clear `rep_cnt`, go to `B_REPEAT`.
    - Otherwise: increment `rep_cnt`.
  - **`B_REPEAT`:** same exits as `B_DELAY`. Pulse `press` and clear `rep_cnt` when `rep_cnt == ARR_CYC-1`.
- **Boundary rules.**
  - A release in the same cycle a repeat is due wins: no pulse, go to `B_IDLE`.
  - Clearing the mask wins over a due repeat.
  - Re-setting the mask while in `B_HOLD` does not resume repeating; a new press is required.
  - A glitch shorter than `DEBOUNCE_CYC` cycles never changes `stable`.
  - A bounce during hold only restarts debounce counting; `stable` stays 1, so no new press.
  - `ARR_CYC=1` produces a pulse every cycle in `B_REPEAT`; this is legal.
- **Reset.**
  - `s1`, `s2`, `stable`, `cnt`, `rep_cnt` go to 0; FSM goes to `B_IDLE`; `press` and `held` go to 0, all asynchronously.
  - A button held through reset is treated as a fresh press after release of reset, following the normal debounce latency.

## Timing

- If `usr_btn[i]` is high from before edge k:
  - `s2` is high after edge k+1.
  - `stable`/`held` are high after edge k+1+`DEBOUNCE_CYC`.
  - `press` is high for exactly one cycle, after edge k+2+`DEBOUNCE_CYC`.
- If the press pulse is registered at edge P, repeats occur at edges P+`DAS_CYC`, then P+`DAS_CYC`+n·`ARR_CYC`.
- Release latency is symmetric: `held` falls `DEBOUNCE_CYC`+1 edges after `s1` samples low.
- `press` and `held` are registered outputs.
- There is no backpressure: pulses are fire-and-forget.

## Structure

- `btn_state_t` (`B_IDLE`, `B_HOLD`, `B_DELAY`, `B_REPEAT`) and default constants `DEBOUNCE_CYC_DEF`, `DAS_CYC_DEF`, `ARR_CYC_DEF` belong in the shared `enum_type` package.
- One sub-module, `btn_debounce`: synchronizer plus debounce for a single bit, with outputs `stable` and `rise`. It is instantiated 4× via generate.
- The FSM lives in `input_repeater` and is generated per bit.

## Test plan

All scenarios use `DEBOUNCE_CYC=4`, `DAS_CYC=10`, `ARR_CYC=3`.

- Glitch: `usr_btn[0]` high for 3 cycles, then low → `press[0]` and `held[0]` stay 0 throughout.
- `usr_btn[1]` held 40 cycles from edge k with mask 0 → `held[1]` rises after edge k+5, a single `press[1]` pulse after edge k+6, no repeats, and `held[1]` falls 5 edges after release.
- `usr_btn[2]` held 40 cycles with mask 1, press pulse at edge P → further pulses at P+10, P+13, P+16, … until release; no pulse after `held` falls.
- Release timing: release lands in `B_DELAY` → no repeat. Release aligned so `stable` falls on the edge where `rep_cnt==ARR_CYC-1` → no pulse. Mask cleared mid-`B_REPEAT` → pulses stop immediately and do not resume when the mask is re-set.
- Assert `reset_n`=0 mid-`B_REPEAT` with the button held → `press`/`held` are 0 without waiting for a clock edge. After deassertion with the button still held → one `press` exactly 6 edges later.
- All four buttons rise on the same edge with mask 4'b0101 → simultaneous `press`=4'b1111. Then repeat pulses appear only on bits 0 and 2.
